// File: rtl/tcount_ctrl.sv
// Interval-timer controller: sequences a chain of 4-bit count nibbles with
// ENP/ENT-style enables, and emits a one-cycle DONE per completed period.
module tcount_ctrl #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         START,
  input  logic         STOP,
  input  logic         PAUSE,
  input  logic         MODE,
  input  logic [W-1:0] TC,
  output logic [W-1:0] Q,
  output logic         BUSY,
  output logic         DONE
);

  localparam int NIB = W / 4;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_q;
  logic [W-1:0]   w_q_nxt;
  logic [W-1:0]   r_tc;
  logic           r_mode;
  logic           r_done;
  logic           w_done_nxt;
  logic           w_run;
  logic           w_term;
  logic           w_enp;
  logic           w_clr;
  logic [NIB-1:0] w_ent;

  assign w_run  = (r_state == RUN);
  assign w_term = w_run && !PAUSE && (r_q == (r_tc - W'(1)));
  assign w_enp  = w_run && !PAUSE && !w_term;
  assign w_clr  = STOP || START || w_term;

  // A nibble may only advance when every lower nibble is at 4'hF.
  for (genvar i = 0; i < NIB; i++) begin : g_ent
    if (i == 0) begin : g_first
      assign w_ent[i] = 1'b1;
    end else begin : g_upper
      assign w_ent[i] = &r_q[4*i-1:0];
    end
  end

  always_comb begin
    w_q_nxt = r_q;
    if (w_clr) begin
      w_q_nxt = '0;
    end else if (w_enp) begin
      for (int i = 0; i < NIB; i++) begin
        if (w_ent[i]) w_q_nxt[4*i +: 4] = r_q[4*i +: 4] + 4'd1;
      end
    end
  end

  always_comb begin
    if (STOP)        w_done_nxt = 1'b0;
    else if (START)  w_done_nxt = (TC == '0);
    else             w_done_nxt = w_term;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (STOP)                    w_state_nxt = IDLE;
    else if (START)              w_state_nxt = (TC != '0) ? RUN : IDLE;
    else if (w_term && !r_mode)  w_state_nxt = IDLE;
  end

  always_comb begin
    BUSY = w_run;
    Q    = r_q;
    DONE = r_done;
  end

  // TC and MODE are captured only on an accepted non-zero START.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_q    <= '0;
      r_tc   <= '0;
      r_mode <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_done <= w_done_nxt;
      if (!STOP && START && (TC != '0)) begin
        r_tc   <= TC;
        r_mode <= MODE;
      end
    end
  end

endmodule

// File: doc/tcount_ctrl.md
# tcount_ctrl

Programmable interval-timer controller built on cascaded 4-bit count nibbles. It sequences the nibble chain's enables (ENP/ENT-style ripple) and clear. It accepts start/stop/pause commands, counts a latched terminal count, and emits a one-cycle DONE pulse in one-shot or periodic mode. It sits between control logic that needs timed events and the nibble counter datapath.

## Interface
- W, default 8: count width in bits; must be a multiple of 4 (W/4 cascaded nibbles).
- CLK  input  1  clock; all state changes on rising edge.
- RESET_N  input  1  synchronous, active-low reset.
- START  input  1  sampled each edge; loads TC and MODE and (re)starts counting from 0.
- STOP  input  1  sampled each edge; aborts and returns to IDLE.
- PAUSE  input  1  level; while high in RUN, the count is frozen.
- MODE  input  1  0 = one-shot, 1 = periodic; latched on START.
- TC  input  W  terminal count (period in cycles); latched on START.
- Q  output  W  current count.
- BUSY  output  1  high while in RUN.
- DONE  output  1  registered one-cycle pulse when the period completes.

## Operation
- Registers: state {IDLE, RUN}, Q, TC_R, MODE_R, DONE.
- Reset (RESET_N=0 at an edge): state=IDLE, Q=0, TC_R=0, MODE_R=0, BUSY=0, DONE=0. Reset overrides all other inputs, including mid-run.
- Command priority per edge: RESET_N > STOP > START > count.
- STOP (any state): state=IDLE, Q=0, DONE=0.
- START, TC≠0 (IDLE or RUN): TC_R=TC, MODE_R=MODE, Q=0, state=RUN, DONE=0. Restart in RUN discards the current period.
- START, TC=0: DONE=1 for one cycle, state=IDLE, Q=0. Applies in both modes; periodic with 0 is treated as one-shot.
- RUN, PAUSE=0, Q≠TC_R-1: Q=Q+1.
- RUN, PAUSE=0, Q=TC_R-1 (terminal): DONE=1 next cycle, Q=0.
  - MODE_R=0: state goes to IDLE.
  - MODE_R=1: state stays RUN and the next period starts immediately.
- RUN, PAUSE=1: Q held. No terminal detection, DONE=0.
- Count structure:
  - Nibble i increments when ENP=(RUN & ~PAUSE & ~terminal) and ENT_i=(all lower nibbles == 4'hF).
  - Nibble 0 has ENT_0=1.
  - On terminal, STOP or START, all nibbles are cleared together.
- TC and MODE input changes during RUN are ignored until the next START. Periodic reload reuses TC_R.
- DONE is high for exactly one cycle per completion and never while BUSY is rising from a START in the same edge.
- In IDLE, Q holds 0 and PAUSE is ignored.

## Timing
- START accepted at edge k:
  - BUSY=1 and Q=0 after edge k.
  - Q=n after edge k+n, for n < TC_R.
  - DONE=1 after edge k+TC_R, for one cycle.
- One-shot: BUSY falls at the same edge DONE rises (k+TC_R).
- Periodic: DONE after edges k+TC_R, k+2·TC_R, …; BUSY stays 1.
- Each paused cycle delays DONE by exactly one cycle.
- Simultaneous events:
  - START and terminal at the same edge: START wins, no DONE, Q=0, new TC_R.
  - STOP and terminal: no DONE.
  - PAUSE and terminal condition: no count, DONE deferred.
- Max TC = 2^W-1, giving a period of 2^W-1 cycles. Q never exceeds TC_R-1 and never wraps through 2^W.
- Nibble carry is combinational within the cycle: 0x0F→0x10 takes one edge.
- Latency from START to first Q change: 1 edge. STOP and RESET_N take effect at the sampling edge.

## Test plan
- Reset: run with TC=9, assert RESET_N=0 for 2 edges when Q=4 -> Q=0, BUSY=0, DONE=0; no DONE afterwards without a new START.
- One-shot: TC=5, MODE=0, START at edge 0 -> Q=0,1,2,3,4 after edges 0-4; DONE=1 and BUSY=0 only after edge 5, Q=0; DONE=0 after edge 6.
- Periodic plus STOP: TC=3, MODE=1, START at edge 0 -> DONE after edges 3 and 6; STOP at edge 7 -> BUSY=0 after edge 7, no DONE at edge 9.
- Pause: TC=6, START at edge 0, PAUSE high across edges 3-6 -> Q holds 2; DONE after edge 10, exactly one cycle.
- Nibble carry and max: TC=20 -> Q steps 0x0F→0x10 at edge 16, DONE after edge 20. TC=255 -> DONE after edge 255. TC=0 -> DONE after edge 0, BUSY stays 0.
- Collision: TC=4 running; at edge 4 (terminal) assert START with TC=2 -> no DONE at edge 4, Q=0, DONE after edge 6.
